tcm_mem_ram_dp: RTL and testbench

Parametrised true dual-port tightly-coupled memory with per-byte write strobes and a per-port read-first/write-first mode. A built-in post-reset clear engine zeroes every word before the ports are released. Cross-port write collisions are arbitrated deterministically and flagged. Sits between the core's instruction/data TCM ports and the bus-side loader port, replacing the fixed 64-bit x 16K dual-port TCM RAM.

---
 rtl/tcm_mem_ram_dp.sv | 223 ++++++++++++++++++++++
 tb/tb_tcm_mem_ram_dp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem_ram_dp.sv
// ============================================================================
// Module   : tcm_mem_ram_dp
// Brief    : True dual-port byte-strobed TCM with post-reset clear engine,
//            per-port read-first/write-first mode and cross-port collision
//            arbitration (port 0 wins overlapping bytes).
// Options  : TCM_RAM_OUTREG_EN adds one output register stage per port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcm_mem_ram_dp #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 14,
  parameter int WF0           = 0,
  parameter int WF1           = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [DATA_W-1:0]     data0_i,
  input  logic [DATA_W/8-1:0]   wr0_i,
  input  logic                  rd0_i,
  output logic [DATA_W-1:0]     data0_o,
  output logic                  valid0_o,

  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W/8-1:0]   wr1_i,
  input  logic                  rd1_i,
  output logic [DATA_W-1:0]     data1_o,
  output logic                  valid1_o,

  output logic                  busy_o,
  output logic                  collision_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;
  logic                collision_q, collision_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                port_en;
  logic                clear_we;
  logic                same_addr;
  logic [NB-1:0]       strb0;
  logic [NB-1:0]       strb1;
  logic [NB-1:0]       we0;
  logic [NB-1:0]       we1;
  logic                rd0_acc;
  logic                rd1_acc;
  logic [DATA_W-1:0]   old0;
  logic [DATA_W-1:0]   old1;
  logic [DATA_W-1:0]   rdata0;
  logic [DATA_W-1:0]   rdata1;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  // Port gating and write arbitration
  always_comb begin
    port_en   = (state_q == ST_READY) && !rst;
    clear_we  = (state_q == ST_CLEAR) && !rst;
    same_addr = (addr0_i == addr1_i);
    strb0     = wr0_i & {NB{port_en}};
    strb1     = wr1_i & {NB{port_en}};
    we0       = strb0;
    // Port 0 owns any byte both ports strobe at the same word
    we1       = strb1 & ~(same_addr ? strb0 : {NB{1'b0}});
    rd0_acc   = rd0_i && port_en;
    rd1_acc   = rd1_i && port_en;
  end

  // Read path: cross-port writes are never visible in the same cycle
  always_comb begin
    old0   = mem_q[addr0_i];
    old1   = mem_q[addr1_i];
    rdata0 = (WF0 != 0) ? merge_bytes(old0, data0_i, strb0) : old0;
    rdata1 = (WF1 != 0) ? merge_bytes(old1, data1_i, strb1) : old1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (&cnt_q) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase

    data0_d     = rd0_acc ? rdata0 : data0_q;
    data1_d     = rd1_acc ? rdata1 : data1_q;
    valid0_d    = rd0_acc;
    valid1_d    = rd1_acc;
    collision_d = port_en && same_addr && (|(wr0_i & wr1_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_ON_RESET != 0) begin
        state_q <= ST_CLEAR;
        busy_q  <= 1'b1;
      end else begin
        state_q <= ST_READY;
        busy_q  <= 1'b0;
      end
      cnt_q       <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      collision_q <= collision_d;
    end
  end

  // Storage array: not reset, zeroed by the clear engine instead
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (we0[b]) mem_q[addr0_i][b*8 +: 8] <= data0_i[b*8 +: 8];
        if (we1[b]) mem_q[addr1_i][b*8 +: 8] <= data1_i[b*8 +: 8];
      end
    end
  end

`ifdef TCM_RAM_OUTREG_EN
  logic [DATA_W-1:0] data0_p_q, data0_p_d;
  logic [DATA_W-1:0] data1_p_q, data1_p_d;
  logic              valid0_p_q, valid0_p_d;
  logic              valid1_p_q, valid1_p_d;
  logic              collision_p_q, collision_p_d;

  always_comb begin
    data0_p_d     = data0_q;
    data1_p_d     = data1_q;
    valid0_p_d    = valid0_q;
    valid1_p_d    = valid1_q;
    collision_p_d = collision_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_p_q     <= '0;
      data1_p_q     <= '0;
      valid0_p_q    <= 1'b0;
      valid1_p_q    <= 1'b0;
      collision_p_q <= 1'b0;
    end else begin
      data0_p_q     <= data0_p_d;
      data1_p_q     <= data1_p_d;
      valid0_p_q    <= valid0_p_d;
      valid1_p_q    <= valid1_p_d;
      collision_p_q <= collision_p_d;
    end
  end

  assign data0_o     = data0_p_q;
  assign data1_o     = data1_p_q;
  assign valid0_o    = valid0_p_q;
  assign valid1_o    = valid1_p_q;
  assign collision_o = collision_p_q;
`else
  assign data0_o     = data0_q;
  assign data1_o     = data1_q;
  assign valid0_o    = valid0_q;
  assign valid1_o    = valid1_q;
  assign collision_o = collision_q;
`endif

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tcm_mem_ram_dp.sv
// ============================================================================
// Module   : tb_tcm_mem_ram_dp
// Brief    : Table-driven scoreboard bench for tcm_mem_ram_dp (16 words,
//            port 0 read-first, port 1 write-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcm_mem_ram_dp;

`ifdef TCM_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr0, addr1;
  logic [63:0] din0, din1;
  logic [7:0]  wr0, wr1;
  logic        rd0, rd1;
  logic [63:0] dout0, dout1;
  logic        valid0, valid1;
  logic        busy, collision;

  tcm_mem_ram_dp #(
    .DATA_W(64), .ADDR_W(4), .WF0(0), .WF1(1), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .addr0_i(addr0), .data0_i(din0), .wr0_i(wr0), .rd0_i(rd0),
    .data0_o(dout0), .valid0_o(valid0),
    .addr1_i(addr1), .data1_i(din1), .wr1_i(wr1), .rd1_i(rd1),
    .data1_o(dout1), .valid1_o(valid1),
    .busy_o(busy), .collision_o(collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    logic [3:0]  a0; logic [63:0] d0; logic [7:0] w0; logic r0; logic [63:0] e0;
    logic [3:0]  a1; logic [63:0] d1; logic [7:0] w1; logic r1; logic [63:0] e1;
    logic        col;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    bit e0, e1, ec;
    if (mon_en) begin
      e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
      e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
      ec = (cq.size() > 0) && (cq[0] == cyc);
      if (e0 || valid0 !== 1'b0) begin
        chk("valid0", {63'd0, valid0}, {63'd0, e0});
        if (e0) begin
          chk("data0", dout0, q0[0].val);
          void'(q0.pop_front());
        end
      end
      if (e1 || valid1 !== 1'b0) begin
        chk("valid1", {63'd0, valid1}, {63'd0, e1});
        if (e1) begin
          chk("data1", dout1, q1[0].val);
          void'(q1.pop_front());
        end
      end
      if (ec || collision !== 1'b0) begin
        chk("collision", {63'd0, collision}, {63'd0, ec});
        if (ec) void'(cq.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    addr0 = '0; din0 = '0; wr0 = '0; rd0 = 1'b0;
    addr1 = '0; din1 = '0; wr1 = '0; rd1 = 1'b0;
  endtask

  task automatic step(input vec_t v);
    addr0 = v.a0; din0 = v.d0; wr0 = v.w0; rd0 = v.r0;
    addr1 = v.a1; din1 = v.d1; wr1 = v.w1; rd1 = v.r1;
    if (v.r0)  q0.push_back('{cyc + LAT, v.e0});
    if (v.r1)  q1.push_back('{cyc + LAT, v.e1});
    if (v.col) cq.push_back(cyc + LAT);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    //          a0  d0                      w0     r0  e0                       a1  d1                      w1     r1  e1                      col
    tbl[0]  = '{4'd5,  64'h0,                 8'h00, 1, 64'h0,                  4'd0,  64'h0,                 8'h00, 1, 64'h0,                  0};
    tbl[1]  = '{4'd3,  64'h1122334455667788, 8'hFF, 0, 64'h0,                  4'd0,  64'h0,                 8'h00, 0, 64'h0,                  0};
    tbl[2]  = '{4'd3,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 64'h0,                  4'd0,  64'h0,                 8'h00, 0, 64'h0,                  0};
    tbl[3]  = '{4'd3,  64'h0,                 8'h00, 1, 64'h11223344AAAAAAAA, 4'd3,  64'h0,                 8'h00, 1, 64'h11223344AAAAAAAA, 0};
    tbl[4]  = '{4'd7,  64'h55,                8'h01, 1, 64'h0,                  4'd0,  64'h0,                 8'h00, 0, 64'h0,                  0};
    tbl[5]  = '{4'd7,  64'h0,                 8'h00, 1, 64'h55,                 4'd0,  64'h0,                 8'h00, 0, 64'h0,                  0};
    tbl[6]  = '{4'd0,  64'h0,                 8'h00, 0, 64'h0,                  4'd8,  64'h66,                8'h01, 1, 64'h66,                 0};
    tbl[7]  = '{4'd9,  64'hAA,                8'h01, 0, 64'h0,                  4'd9,  64'hBBCC,              8'h03, 0, 64'h0,                  1};
    tbl[8]  = '{4'd9,  64'h0,                 8'h00, 1, 64'hBBAA,               4'd9,  64'h0,                 8'h00, 1, 64'hBBAA,               0};
    tbl[9]  = '{4'd10, 64'h11,                8'h01, 0, 64'h0,                  4'd10, 64'h2200,              8'h02, 0, 64'h0,                  0};
    tbl[10] = '{4'd10, 64'h33,                8'h01, 0, 64'h0,                  4'd10, 64'h0,                 8'h00, 1, 64'h2211,               0};
    tbl[11] = '{4'd10, 64'h0,                 8'h00, 1, 64'h2233,               4'd10, 64'h4400,              8'h02, 0, 64'h0,                  0};
    tbl[12] = '{4'd10, 64'h0,                 8'h00, 1, 64'h4433,               4'd3,  64'h0,                 8'h00, 1, 64'h11223344AAAAAAAA, 0};
    tbl[13] = '{4'd12, 64'h77,                8'h01, 0, 64'h0,                  4'd13, 64'h88,                8'h01, 0, 64'h0,                  0};
    tbl[14] = '{4'd13, 64'h0,                 8'h00, 1, 64'h88,                 4'd12, 64'h0,                 8'h00, 1, 64'h77,                 0};
    tbl[15] = '{4'd14, 64'h0101010101010101, 8'hFF, 0, 64'h0,                  4'd14, 64'h0202020202020202, 8'hFF, 0, 64'h0,                  1};
    tbl[16] = '{4'd14, 64'h0,                 8'h00, 1, 64'h0101010101010101, 4'd14, 64'h0,                 8'h00, 1, 64'h0101010101010101, 0};
    tbl[17] = '{4'd6,  64'hDEAD,              8'hFF, 1, 64'h0,                  4'd6,  64'h0,                 8'h00, 1, 64'h0,                  0};
    tbl[18] = '{4'd6,  64'h0,                 8'h00, 1, 64'hDEAD,               4'd8,  64'h0,                 8'h00, 1, 64'h66,                 0};

    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy",      {63'd0, busy},      64'd1);
    chk("rst_data0",     dout0,              64'd0);
    chk("rst_data1",     dout1,              64'd0);
    chk("rst_valid0",    {63'd0, valid0},    64'd0);
    chk("rst_valid1",    {63'd0, valid1},    64'd0);
    chk("rst_collision", {63'd0, collision}, 64'd0);

    // Hammer both ports during the clear; every access must be dropped
    rst = 1'b0;
    rd0 = 1'b1; rd1 = 1'b1;
    wr0 = 8'hFF; addr0 = 4'd0; din0 = 64'hDEAD_BEEF_0000_0000;
    wr1 = 8'hFF; addr1 = 4'd1; din1 = 64'hCAFE_0000_0000_CAFE;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("busy_mid_clear", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("busy_during_rst", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (busy && c < 100);
    chk("clear_cycles", 64'(c), 64'd16);
    idle_inputs();

    for (int i = 0; i < 19; i++) step(tbl[i]);
    idle_inputs();

    repeat (LAT + 3) begin
      @(posedge clk); #1;
    end
    chk("hold_data0", dout0, 64'hDEAD);
    chk("hold_data1", dout1, 64'h66);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("cq_drained", 64'(cq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
